fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It sits directly upstream of the instruction memory: it owns the program counter, drives the word address into the memory, and captures the returned instruction into the IF/ID pipeline register for the decode stage. It handles hazard-unit stalls, taken-branch redirects with flush, and halts fetch when an `ecall` is fetched.

---
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Owns the PC, addresses a combinational instruction memory and registers the
// returned word into IF/ID. Handles stall, redirect+flush, and halts on ecall.
module fetch_stage #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc4,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic {RUN, HALTED} state_e;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{pc: 32'h0, pc4: 32'h0, instr: NOP, valid: 1'b0};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  logic        halted_q, halted_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  // Low two bits of the redirect target are dropped by word alignment.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^branch_target[1:0];

  // Next-state selection: flush beats halt-hold, which beats stall, which beats fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_d       = if_id_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    if (flush) begin
      pc_d     = {branch_target[31:2], 2'b00};
      if_id_d  = BUBBLE;
      state_d  = RUN;
      halted_d = 1'b0;
    end else if (state_q == HALTED) begin
      // Holding under stall keeps the captured ecall visible to decode.
      if (!stall) if_id_d = BUBBLE;
    end else if (!stall) begin
      if_id_d.pc    = pc_q;
      if_id_d.pc4   = pc_q + 32'd4;
      if_id_d.instr = imem_data;
      if_id_d.valid = 1'b1;
      pc_d          = pc_q + 32'd4;
      if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
      if (imem_data == ECALL) begin
        state_d  = HALTED;
        halted_d = 1'b1;
      end
    end
  end

  // All state registers; synchronous reset has top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      if_id_q       <= BUBBLE;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Word index into the memory; wraps naturally past its end.
  assign imem_addr   = pc_q[ADDR_W+1:2];
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural model pushes expected outputs into a
// queue per edge; they are popped and compared after the edge.
module tb_fetch_stage;
  localparam int ADDR_W = 6;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic [31:0]       branch_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       if_id_pc, if_id_pc4, if_id_instr;
  logic              if_id_valid, halted;
  logic [15:0]       fetch_count;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  typedef struct {
    logic [31:0] pc, pc4, instr;
    logic        valid, halted;
    logic [15:0] cnt;
    logic [5:0]  addr;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid, m_halt;
  logic [15:0] m_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Advance the model one edge, drive inputs, clock, then compare.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic [31:0] tgt, input bit do_chk = 1'b1);
    exp_t e, g;
    logic [31:0] w;
    rst = r; stall = s; flush = f; branch_target = tgt;
    if (r) begin
      m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0; m_halt = 0; m_cnt = 0;
    end else if (f) begin
      m_pc = {tgt[31:2], 2'b00}; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0; m_halt = 0;
    end else if (m_halt) begin
      if (!s) begin m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0; end
    end else if (!s) begin
      w = mem[m_pc[7:2]];
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = w; m_valid = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (w == ECALL) m_halt = 1;
      m_pc = m_pc + 4;
    end
    e.pc = m_ipc; e.pc4 = m_ipc4; e.instr = m_instr; e.valid = m_valid;
    e.halted = m_halt; e.cnt = m_cnt; e.addr = m_pc[7:2];
    if (do_chk) exp_q.push_back(e);
    @(posedge clk); #1;
    if (do_chk) begin
      g = exp_q.pop_front();
      chk("if_id_pc",    if_id_pc,    g.pc);
      chk("if_id_pc4",   if_id_pc4,   g.pc4);
      chk("if_id_instr", if_id_instr, g.instr);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, g.valid});
      chk("halted",      {31'b0, halted},      {31'b0, g.halted});
      chk("fetch_count", {16'b0, fetch_count}, {16'b0, g.cnt});
      chk("imem_addr",   {26'b0, imem_addr},   {26'b0, g.addr});
    end
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; branch_target = 0;
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[5] = ECALL;
    @(negedge clk);

    // Reset, free run into ecall, then halted hold
    step(1, 0, 0, 0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_addr", {26'b0, imem_addr}, 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    chk("ecall_cap", if_id_instr, ECALL);
    chk("ecall_pc", if_id_pc, 32'd20);
    chk("halt_rise", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("halt_pc", {26'b0, imem_addr}, 32'd6);
    chk("halt_cnt", {16'b0, fetch_count}, 32'd6);
    chk("halt_bubble", {31'b0, if_id_valid}, 32'd0);

    // Flush while halted restarts from 0
    step(0, 0, 1, 32'h0);
    chk("flush_halt_drop", {31'b0, halted}, 32'd0);
    step(0, 0, 0, 0);
    chk("restart_pc", if_id_pc, 32'd0);

    // Stall for 3 cycles after edge 2
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("stall_ifpc", if_id_pc, 32'd4);
    chk("stall_cnt", {16'b0, fetch_count}, 32'd2);
    step(0, 0, 0, 0);
    chk("resume_pc", if_id_pc, 32'd8);

    // Flush with misaligned target while stalled at pc=8
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_000E);
    chk("flush_bubble", if_id_instr, NOP);
    chk("flush_align", {26'b0, imem_addr}, 32'd3);
    step(0, 0, 0, 0);
    chk("redirect_pc", if_id_pc, 32'h0C);

    // Stall right after ecall capture keeps it visible
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    chk("stall_ecall", if_id_instr, ECALL);
    step(0, 0, 0, 0);
    chk("ecall_then_bubble", {31'b0, if_id_valid}, 32'd0);

    // Reset while halted and stalled
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_halt", {31'b0, halted}, 32'd0);
    step(0, 0, 0, 0);
    chk("rst_restart", if_id_pc, 32'd0);

    // Long run: memory wrap and fetch_count saturation
    mem[5] = NOP;
    mem[9] = 32'h0012_8093;
    step(1, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 65500; i++) step(0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("cnt_sat", {16'b0, fetch_count}, 32'h0000_FFFF);
    chk("wrap_addr", {26'b0, imem_addr}, {26'b0, 6'(65574 % 64)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
